// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the tx FIFO write-port arbiter.
// Imported by the round-robin picker and the arbiter top.
package tx_arb_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    localparam int MAX_REQ    = 4;
    localparam int BYTE_W     = 8;
    localparam int IDLE_CNT_W = 8;
    localparam int IDX_W      = $clog2(MAX_REQ);

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted request
// searching upward from the slot after the last owner.
module rr_select
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx
);

    logic found;
    int   c;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        c       = 0;
        // last < NUM_REQ and k <= NUM_REQ, so one subtraction wraps
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(last) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[c]) begin
                found   = 1'b1;
                win[c]  = 1'b1;
                win_idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Burst-granular round-robin arbiter in front of the tx FIFO
// write port, with idle timeout and zero-latency pass-through.
module tx_fifo_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int IDLE_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      write_enable,
    output logic [BYTE_W-1:0]         write_data,
    output logic                      burst_abort,
    output logic [7:0]                byte_count
);

    state_t                state, state_n;
    logic [NUM_REQ-1:0]    grant_n;
    logic [IDX_W-1:0]      owner, owner_n;
    logic [IDX_W-1:0]      last_owner, last_owner_n;
    logic [7:0]            byte_count_n;
    logic [IDLE_CNT_W-1:0] idle_cnt, idle_cnt_n;

    logic [NUM_REQ-1:0]    win;
    logic [IDX_W-1:0]      win_idx;

    logic                  sel_req;
    logic                  sel_last;
    logic [BYTE_W-1:0]     sel_data;
    logic                  fire;
    logic                  idle_hit;

    rr_select #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_select (
        .req     (req),
        .last    (last_owner),
        .win     (win),
        .win_idx (win_idx)
    );

    // grant is all-zero in IDLE, so the mux output is zero there too
    always_comb begin
        sel_req  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_req  = req[i];
                sel_last = req_last[i];
                sel_data = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign fire     = (state == BURST) && sel_req && !fifo_full;
    assign idle_hit = (state == BURST) && !sel_req && !fifo_full &&
                      (idle_cnt == IDLE_CNT_W'(IDLE_TIMEOUT - 1));

    assign ack          = fire ? grant : '0;
    assign write_enable = fire;
    assign write_data   = sel_data;
    assign burst_abort  = idle_hit;

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        owner_n      = owner;
        last_owner_n = last_owner;
        byte_count_n = byte_count;
        idle_cnt_n   = idle_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_n      = BURST;
                    grant_n      = win;
                    owner_n      = win_idx;
                    byte_count_n = '0;
                    idle_cnt_n   = '0;
                end
            end
            BURST: begin
                if (fire) begin
                    idle_cnt_n = '0;
                    if (byte_count != 8'hFF) begin
                        byte_count_n = byte_count + 8'd1;
                    end
                    if (sel_last) begin
                        state_n      = IDLE;
                        grant_n      = '0;
                        last_owner_n = owner;
                    end
                end else if (idle_hit) begin
                    state_n      = IDLE;
                    grant_n      = '0;
                    last_owner_n = owner;
                end else if (!fifo_full) begin
                    idle_cnt_n = idle_cnt + IDLE_CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IDX_W'(NUM_REQ - 1);
            byte_count <= '0;
            idle_cnt   <= '0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            byte_count <= byte_count_n;
            idle_cnt   <= idle_cnt_n;
        end
    end

endmodule
